// File: rtl/grover_iter_ctrl.sv
// -----------------------------------------------------------------------------
// grover_iter_ctrl
//
// Sequencer for an 8-sample Grover search model. It owns the amplitude
// register file and loads it with a uniform superposition. For ITER
// iterations it applies an oracle phase flip on the target sample, then one
// inversion-about-mean pass through an external combinational datapath. It
// ends with an 8-cycle argmax scan that reports the winning index and value.
//
// Optional build macro: GROVER_SAT_EN
//   defined   : oracle negation saturates, so -(-128) = +127
//   undefined : plain two's-complement negation, so -(-128) = -128
//
// Parameters
//   ITER     : number of oracle + diffusion iterations (0 is legal)
//   ITER_W   : iteration counter width; ITER <= 2**ITER_W - 1
//   INIT_AMP : initial signed Q1.6 amplitude loaded into every sample
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   single-cycle run request, sampled only in IDLE
//   target     in   marked index, latched when start is accepted
//   busy       out  high whenever the sequencer is not IDLE
//   done       out  one-cycle registered completion pulse
//   result_idx out  argmax index, held until the next accepted start
//   result_amp out  signed amplitude at result_idx
//   amp_q      out  amplitude registers, sample i at bits [8i+7:8i]
//   dif_in     out  diffusion datapath inputs (identical to amp_q)
//   dif_out    in   diffusion datapath outputs, same packing
// -----------------------------------------------------------------------------
module grover_iter_ctrl #(
  parameter int unsigned       ITER     = 2,
  parameter int unsigned       ITER_W   = 4,
  parameter logic signed [7:0] INIT_AMP = 8'sd23
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          target,
  output logic                busy,
  output logic                done,
  output logic [2:0]          result_idx,
  output logic signed [7:0]   result_amp,
  output logic [63:0]         amp_q,
  output logic [63:0]         dif_in,
  input  logic [63:0]         dif_out
);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StOracle,
    StDiffuse,
    StScan,
    StDone
  } state_e;

  state_e              r_state;
  logic [63:0]         r_amp;
  logic [2:0]          r_target;
  logic [ITER_W-1:0]   r_iter;
  logic [2:0]          r_ptr;
  logic [2:0]          r_best_idx;
  logic signed [7:0]   r_best_amp;
  logic [2:0]          r_result_idx;
  logic signed [7:0]   r_result_amp;
  logic                r_busy;
  logic                r_done;

  logic signed [7:0]   w_tgt_amp;
  logic signed [7:0]   w_neg_raw;
  logic signed [7:0]   w_neg;
  logic signed [7:0]   w_scan_amp;
  logic                w_take;
  logic [2:0]          w_new_best_idx;
  logic signed [7:0]   w_new_best_amp;
  logic [ITER_W-1:0]   w_iter_inc;
  logic                w_last_iter;

  // Oracle: negate the target sample.
  always_comb begin
    w_tgt_amp = r_amp[{r_target, 3'b000} +: 8];
    w_neg_raw = -w_tgt_amp;
`ifdef GROVER_SAT_EN
    w_neg     = (w_tgt_amp == 8'sh80) ? 8'sh7f : w_neg_raw;
`else
    w_neg     = w_neg_raw;
`endif
  end

  // Argmax step: pointer 0 always loads; later samples need strictly greater
  // so ties keep the lowest index.
  always_comb begin
    w_scan_amp     = r_amp[{r_ptr, 3'b000} +: 8];
    w_take         = (r_ptr == 3'd0) || (w_scan_amp > r_best_amp);
    w_new_best_idx = w_take ? r_ptr      : r_best_idx;
    w_new_best_amp = w_take ? w_scan_amp : r_best_amp;
  end

  always_comb begin
    w_iter_inc  = r_iter + 1'b1;
    w_last_iter = (w_iter_inc == ITER_W'(ITER));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_amp        <= '0;
      r_target     <= '0;
      r_iter       <= '0;
      r_ptr        <= '0;
      r_best_idx   <= '0;
      r_best_amp   <= '0;
      r_result_idx <= '0;
      r_result_amp <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_target     <= target;
            r_iter       <= '0;
            r_result_idx <= '0;
            r_result_amp <= '0;
            r_busy       <= 1'b1;
            r_state      <= StInit;
          end
        end
        StInit: begin
          r_amp <= {8{INIT_AMP}};
          r_ptr <= '0;
          if (ITER == 0) r_state <= StScan;
          else           r_state <= StOracle;
        end
        StOracle: begin
          r_amp[{r_target, 3'b000} +: 8] <= w_neg;
          r_state                        <= StDiffuse;
        end
        StDiffuse: begin
          r_amp  <= dif_out;
          r_iter <= w_iter_inc;
          r_ptr  <= '0;
          if (w_last_iter) r_state <= StScan;
          else             r_state <= StOracle;
        end
        StScan: begin
          r_best_idx <= w_new_best_idx;
          r_best_amp <= w_new_best_amp;
          r_ptr      <= r_ptr + 3'd1;
          if (r_ptr == 3'd7) begin
            r_result_idx <= w_new_best_idx;
            r_result_amp <= w_new_best_amp;
            r_done       <= 1'b1;
            r_state      <= StDone;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign result_idx = r_result_idx;
  assign result_amp = r_result_amp;
  assign amp_q      = r_amp;
  assign dif_in     = r_amp;

endmodule

// File: tb/tb_grover_iter_ctrl.sv
module tb_grover_iter_ctrl;

  logic clk;
  logic rst_n;

  logic        start_m, start_z, start_n, start_s;
  logic [2:0]  target_m, target_z, target_n, target_s;
  logic        busy_m, busy_z, busy_n, busy_s;
  logic        done_m, done_z, done_n, done_s;
  logic [2:0]  ridx_m, ridx_z, ridx_n, ridx_s;
  logic [7:0]  ramp_m, ramp_z, ramp_n, ramp_s;
  logic [63:0] amp_m, amp_z, amp_n, amp_s;
  logic [63:0] din_m, din_z, din_n, din_s;
  logic [63:0] dout_m, dout_z, dout_n, dout_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference inversion-about-mean: y[i] = (sum >>> 2) - x[i], truncated to 8 bits.
  function automatic logic [63:0] diffuse(input logic [63:0] x);
    logic signed [10:0] sum;
    logic signed [10:0] m;
    logic signed [10:0] d;
    logic [63:0]        y;
    sum = '0;
    for (int i = 0; i < 8; i++) sum = sum + {{3{x[8*i+7]}}, x[8*i +: 8]};
    m = sum >>> 2;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      d = m - {{3{x[8*i+7]}}, x[8*i +: 8]};
      y[8*i +: 8] = d[7:0];
    end
    return y;
  endfunction

  assign dout_m = diffuse(din_m);
  assign dout_z = diffuse(din_z);
  assign dout_n = diffuse(din_n);
  assign dout_s = 64'hff64_ffff_ffff_ffff;

  grover_iter_ctrl u_dut_m (
    .clk(clk), .rst_n(rst_n), .start(start_m), .target(target_m), .busy(busy_m),
    .done(done_m), .result_idx(ridx_m), .result_amp(ramp_m), .amp_q(amp_m),
    .dif_in(din_m), .dif_out(dout_m)
  );

  grover_iter_ctrl #(.ITER(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .start(start_z), .target(target_z), .busy(busy_z),
    .done(done_z), .result_idx(ridx_z), .result_amp(ramp_z), .amp_q(amp_z),
    .dif_in(din_z), .dif_out(dout_z)
  );

  grover_iter_ctrl #(.ITER(1), .INIT_AMP(8'sh80)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .start(start_n), .target(target_n), .busy(busy_n),
    .done(done_n), .result_idx(ridx_n), .result_amp(ramp_n), .amp_q(amp_n),
    .dif_in(din_n), .dif_out(dout_n)
  );

  grover_iter_ctrl #(.ITER(3)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .target(target_s), .busy(busy_s),
    .done(done_s), .result_idx(ridx_s), .result_amp(ramp_s), .amp_q(amp_s),
    .dif_in(din_s), .dif_out(dout_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Returns the edge number at which done is first seen, or -1 if the bound expires.
  task automatic wait_done(input int sel, input int first, output int e);
    logic d;
    e = -1;
    for (int k = first; k < first + 40; k++) begin
      tick();
      case (sel)
        0:       d = done_m;
        1:       d = done_z;
        2:       d = done_n;
        default: d = done_s;
      endcase
      if (d) begin
        e = k;
        break;
      end
    end
  endtask

  int  e;
  int  ndone;
  int  first_done;
  logic amp_moved;
  logic [7:0] neg_exp;

  initial begin
    rst_n = 1'b0;
    start_m = 0; start_z = 0; start_n = 0; start_s = 0;
    target_m = 0; target_z = 0; target_n = 0; target_s = 0;
`ifdef GROVER_SAT_EN
    neg_exp = 8'h7f;
`else
    neg_exp = 8'h80;
`endif
    tick(); tick(); tick();

    // Reset state
    check("rst_busy",   64'(busy_m), 64'd0);
    check("rst_done",   64'(done_m), 64'd0);
    check("rst_ridx",   64'(ridx_m), 64'd0);
    check("rst_ramp",   64'(ramp_m), 64'd0);
    check("rst_amp_q",  amp_m, 64'd0);
    check("rst_dif_in", din_m, 64'd0);

    // Main run, target 5; start on the first cycle after reset release
    rst_n = 1'b1; start_m = 1'b1; target_m = 3'd5;
    tick();                                   // edge 0
    start_m = 1'b0;
    check("busy_after_start", 64'(busy_m), 64'd1);
    tick();                                   // edge 1
    check("init_amp", amp_m, 64'h1717_1717_1717_1717);
    tick();                                   // edge 2
    check("oracle1_amp", amp_m, 64'h1717_e917_1717_1717);
    tick();                                   // edge 3
    check("iter1_amp", amp_m, 64'h0b0b_390b_0b0b_0b0b);
    check("dif_in_eq_amp", din_m, 64'h0b0b_390b_0b0b_0b0b);
    tick(); tick();                           // edges 4, 5
    check("iter2_amp", amp_m, 64'hfafa_3efa_fafa_fafa);
    wait_done(0, 6, e);
    check("done_edge", 64'(e), 64'd13);
    check("result_idx", 64'(ridx_m), 64'd5);
    check("result_amp", 64'(ramp_m), 64'd62);
    tick();
    check("done_pulse_end", 64'(done_m), 64'd0);
    check("busy_end", 64'(busy_m), 64'd0);
    check("result_held", 64'(ridx_m), 64'd5);

    // Held start, mid-run target change, extra start during SCAN
    start_m = 1'b1; target_m = 3'd5;
    tick();                                   // edge 0
    for (int k = 1; k <= 4; k++) tick();
    start_m = 1'b0; target_m = 3'd2;
    ndone = 0; first_done = -1;
    for (int k = 5; k <= 40; k++) begin
      tick();
      if (k == 8) start_m = 1'b1;
      if (k == 9) start_m = 1'b0;
      if (done_m) begin
        ndone++;
        first_done = k;
      end
    end
    check("hold_done_count", 64'(ndone), 64'd1);
    check("hold_done_edge", 64'(first_done), 64'd13);
    check("hold_result_idx", 64'(ridx_m), 64'd5);
    check("hold_idle", 64'(busy_m), 64'd0);

    // Reset asserted at edge 6 of a run
    start_m = 1'b1; target_m = 3'd5;
    tick();                                   // edge 0
    start_m = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    rst_n = 1'b0;
    tick();                                   // edge 6
    check("midrst_busy", 64'(busy_m), 64'd0);
    check("midrst_amp_q", amp_m, 64'd0);
    check("midrst_ridx", 64'(ridx_m), 64'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done_m) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    start_m = 1'b1; target_m = 3'd5;
    tick();
    start_m = 1'b0;
    wait_done(0, 1, e);
    check("rerun_done_edge", 64'(e), 64'd13);
    check("rerun_ridx", 64'(ridx_m), 64'd5);
    check("rerun_ramp", 64'(ramp_m), 64'd62);

    // ITER = 0, target 3: amplitudes never leave the initial value
    start_z = 1'b1; target_z = 3'd3;
    tick();
    start_z = 1'b0;
    amp_moved = 1'b0; first_done = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (busy_z && amp_z !== 64'h1717_1717_1717_1717) amp_moved = 1'b1;
      if (done_z && first_done < 0) first_done = k;
    end
    check("iter0_no_oracle", 64'(amp_moved), 64'd0);
    check("iter0_done_edge", 64'(first_done), 64'd9);
    check("iter0_ridx", 64'(ridx_z), 64'd0);
    check("iter0_ramp", 64'(ramp_z), 64'd23);

    // INIT_AMP = -128, ITER = 1, target 0: oracle negation of -128
    start_n = 1'b1; target_n = 3'd0;
    tick();
    start_n = 1'b0;
    tick();
    check("neg_init", amp_n, 64'h8080_8080_8080_8080);
    tick();
    check("neg_dif_in0", 64'(din_n[7:0]), 64'(neg_exp));
    wait_done(2, 3, e);
    check("neg_done_edge", 64'(e), 64'd11);

    // Constant stub datapath, ITER = 3
    start_s = 1'b1; target_s = 3'd1;
    tick();
    start_s = 1'b0;
    wait_done(3, 1, e);
    check("stub_done_edge", 64'(e), 64'd15);
    check("stub_ridx", 64'(ridx_s), 64'd6);
    check("stub_ramp", 64'(ramp_s), 64'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grover_iter_ctrl.md
# grover_iter_ctrl

Sequencer for the 8-sample Grover search model. It owns the amplitude register file and initializes it to a uniform superposition. For a fixed number of iterations it applies the oracle phase flip on a target index, then one diffusion (2·mean − x) pass through the external combinational inversion-about-mean datapath. It finishes with an 8-cycle argmax scan that reports the found index.

## Interface
Parameters:
- `ITER`, default 2: number of Grover iterations (oracle + diffusion); 0 is legal.
- `ITER_W`, default 4: width of the iteration counter; `ITER` must be ≤ 2^`ITER_W` − 1.
- `INIT_AMP`, default 23: signed 8-bit initial amplitude, Q1.6 (1.0 = 64, 23 ≈ 1/√8).

Ports:
- `clk` in 1: clock; all logic is rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `target` in 3: marked index; latched when `start` is accepted.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse, registered.
- `result_idx` out 3: argmax index; valid from `done`, held until the next accepted `start`.
- `result_amp` out 8 signed: amplitude at `result_idx`; same validity as `result_idx`.
- `amp_q` out 64: amplitude registers, sample i at bits [8i+7:8i], signed.
- `dif_in` out 64: drives the diffusion datapath inputs; equals `amp_q` at all times.
- `dif_out` in 64: diffusion datapath outputs (same packing); combinational from `dif_in`.

## Operation
States are IDLE, INIT, ORACLE, DIFFUSE, SCAN, DONE.
- IDLE: when `start`=1, latch `target`, clear the iteration counter, clear `result_idx`/`result_amp`, and go to INIT. Otherwise hold.
- INIT: load all 8 amplitudes with `INIT_AMP`. Go to SCAN if `ITER`=0, else go to ORACLE.
- ORACLE: amp[target] ← −amp[target] in 8-bit two's complement; other samples unchanged. Go to DIFFUSE.
- DIFFUSE: amp[i] ← `dif_out`[i] for all i, and increment the iteration counter. Go to SCAN if the incremented count = `ITER`, else go to ORACLE.
- SCAN: 8 cycles with a scan pointer p = 0..7.
  - p=0 loads the best value with amp[0] at index 0.
  - p>0 replaces the best value only if amp[p] > best (strict, signed), so ties resolve to the lowest index.
  - After p=7, write the best index and value to `result_idx`/`result_amp` and go to DONE.
- DONE: `done`=1 for this cycle only, then go to IDLE.

Arithmetic rules:
- Negation of −128 wraps to −128, unless `GROVER_SAT_EN` is defined (see Configuration).
- The datapath's sum>>2 floor-shift and 8-bit truncation are accepted as-is. The controller does no range checking of `dif_out`.

## Timing
- Take the edge that samples `start` in IDLE as edge 0.
  - The INIT load happens at edge 1.
  - Iteration n (1-based) does ORACLE at edge 2n and DIFFUSE capture at edge 2n+1.
  - SCAN occupies the 8 edges after the last DIFFUSE.
  - `done` rises at edge 1 + 2·`ITER` + 8, which is 13 for the default `ITER`.
- `busy` rises after edge 0 and falls after the DONE cycle. Back-to-back runs have one IDLE cycle between them.
- `start` while `busy`=1 is ignored; there is no queuing. A `target` change mid-run has no effect.
- `dif_out` is sampled only in DIFFUSE. The external datapath has zero latency, and its settling must fit in one cycle.
- Reset values, forced by `rst_n`=0 at any edge including mid-run:
  - state IDLE;
  - `busy`=0, `done`=0;
  - `result_idx`=0, `result_amp`=0;
  - all amplitudes 0, so `amp_q`=0 and `dif_in`=0;
  - iteration counter and scan pointer 0.
- `start` on the first cycle after `rst_n` rises is accepted.

## Configuration
- `GROVER_SAT_EN` defined: the ORACLE negation saturates, so −(−128) = +127.
- `GROVER_SAT_EN` undefined: plain two's-complement negation, so −(−128) = −128.
- No other behaviour differs between the two builds.

## Test plan
- Default parameters, `target`=5, real diffusion datapath attached:
  - after iteration 1, `amp_q` shows 11 at all i≠5 and 57 at i=5;
  - after iteration 2, it shows −6 and 62;
  - `done` pulses 13 cycles after the `start` edge with `result_idx`=5, `result_amp`=62.
- `ITER`=0, `target`=3 → `done` at edge 9 with `result_idx`=0 (tie → lowest index), `result_amp`=23, and no ORACLE/DIFFUSE states visited.
- `start`=1 held for 5 cycles with `target`=5, then `target` switched to 2 mid-run → exactly one run with `result_idx`=5; a second `start` issued during SCAN is ignored.
- `rst_n`=0 for one cycle at edge 6 of a run → next cycle shows `busy`=0, `amp_q`=0, `result_idx`=0, and no `done` pulse; a fresh `start` completes normally.
- `INIT_AMP`=−128, `ITER`=1, `target`=0 → in the DIFFUSE cycle, `dif_in` sample 0 reads −128 without `GROVER_SAT_EN` and +127 with it.
- Stub datapath returning a constant pattern with sample 6 = 100 and the rest = −1, `ITER`=3 → `result_idx`=6 and `result_amp`=100.
